// File: rtl/mem_read_arbiter.sv
// Read-port TDM arbiter with latency-matched return tags, plus round-robin free-list release arbiter.
// Optional per-port read-grant counters (rd_cnt_o) when MEM_RD_STATS_EN is defined.
module mem_read_arbiter #(
  parameter int N          = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 512,
  parameter int RD_LAT     = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               mem_re_i,
  input  logic [N-1:0][ADDR_W-1:0]   mem_raddr_i,
  output logic [N-1:0]               mem_rgnt_o,
  output logic [N-1:0]               mem_rvalid_o,
  output logic [BLOCK_BITS-1:0]      mem_rdata_o,
  output logic                       mem_re_o,
  output logic [ADDR_W-1:0]          mem_raddr_o,
  input  logic [BLOCK_BITS-1:0]      mem_rdata_i,
  input  logic [N-1:0]               fl_free_req_i,
  input  logic [N-1:0][ADDR_W-1:0]   fl_free_idx_i,
  output logic [N-1:0]               fl_free_ack_o,
  output logic                       fl_free_req_o,
  output logic [ADDR_W-1:0]          fl_free_idx_o,
  input  logic                       fl_free_gnt_i
`ifdef MEM_RD_STATS_EN
  ,
  output logic [N-1:0][31:0]         rd_cnt_o
`endif
);

  localparam int CUR_W = $clog2(N);
  typedef logic [CUR_W-1:0] port_t;
  typedef logic [CUR_W:0]   scan_t;

  // ---------------- read path ----------------
  port_t cur_q, cur_d;

  assign cur_d = (cur_q == port_t'(N - 1)) ? '0 : cur_q + port_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_q <= '0;
    else        cur_q <= cur_d;
  end

  assign mem_re_o    = mem_re_i[cur_q];
  assign mem_raddr_o = mem_raddr_i[cur_q];
  assign mem_rdata_o = mem_rdata_i;

  // Tag stage k carries the slot owner of a read issued k+1 cycles ago.
  logic  tag_vld_q  [RD_LAT];
  port_t tag_port_q [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q[0]  <= 1'b0;
      tag_port_q[0] <= '0;
    end else begin
      tag_vld_q[0]  <= mem_re_o;
      tag_port_q[0] <= cur_q;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q[gi]  <= 1'b0;
          tag_port_q[gi] <= '0;
        end else begin
          tag_vld_q[gi]  <= tag_vld_q[gi-1];
          tag_port_q[gi] <= tag_port_q[gi-1];
        end
      end
    end

    for (gi = 0; gi < N; gi++) begin : g_port
      assign mem_rgnt_o[gi]   = mem_re_i[gi] && (cur_q == port_t'(gi));
      assign mem_rvalid_o[gi] = tag_vld_q[RD_LAT-1] && (tag_port_q[RD_LAT-1] == port_t'(gi));
    end
  endgenerate

  // ---------------- free-list release path ----------------
  typedef enum logic [1:0] {FR_IDLE, FR_WAIT, FR_ACK} fr_state_e;

  fr_state_e             state_q, state_d;
  port_t                 rr_ptr_q, rr_ptr_d;
  port_t                 sel_q, sel_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  win_vld;
  port_t                 win_port;
  scan_t                 scan;

  always_comb begin
    win_vld  = 1'b0;
    win_port = '0;
    scan     = '0;
    for (int i = 0; i < N; i++) begin
      scan = {1'b0, rr_ptr_q} + scan_t'(i);
      if (scan >= scan_t'(N)) scan = scan - scan_t'(N);
      if (!win_vld && fl_free_req_i[scan[CUR_W-1:0]]) begin
        win_vld  = 1'b1;
        win_port = scan[CUR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    case (state_q)
      FR_IDLE: begin
        if (win_vld) begin
          sel_d   = win_port;
          idx_d   = fl_free_idx_i[win_port];
          state_d = FR_WAIT;
        end
      end
      FR_WAIT: begin
        if (fl_free_gnt_i) begin
          rr_ptr_d = (sel_q == port_t'(N - 1)) ? '0 : sel_q + port_t'(1);
          state_d  = FR_ACK;
        end
      end
      FR_ACK:  state_d = FR_IDLE;
      default: state_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FR_IDLE;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
    end
  end

  assign fl_free_req_o = (state_q == FR_WAIT);
  assign fl_free_idx_o = idx_q;

  generate
    for (gi = 0; gi < N; gi++) begin : g_ack
      assign fl_free_ack_o[gi] = (state_q == FR_ACK) && (sel_q == port_t'(gi));
    end
  endgenerate

`ifdef MEM_RD_STATS_EN
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [31:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt_q <= '0;
        else if (mem_rgnt_o[gi] && (cnt_q != '1))  cnt_q <= cnt_q + 32'd1;
      end
      assign rd_cnt_o[gi] = cnt_q;
    end
  endgenerate
`endif

endmodule
